// File: rtl/alu_pipe.sv
// Registered ALU with iterative shift-add multiply and valid/ready on both sides.
// Latency: 1 edge for logic/arith/shift ops, WIDTH+1 edges for MUL (one op in flight).
// Backpressure: result held in HOLD until out_ready; in_ready follows out_ready there.
//
// Ports:
//   clk, reset              clock (rising) and asynchronous active-high reset
//   in_valid/in_ready       operand handshake; a, b, op captured on accept
//   a, b, op                operands (b[SHW-1:0] doubles as shift amount), opcode
//   out_valid/out_ready     result handshake
//   result, carryout, overflow, zero, illegal   registered result and flags
module alu_pipe #(
  parameter int WIDTH      = 32,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q, ovf_q, zero_q, illegal_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;

  logic                   accept;
  logic [WIDTH:0]         add_w, sub_w;
  logic                   ovf_add, ovf_sub;
  logic [SHW-1:0]         shamt;
  logic signed [WIDTH-1:0] a_s;
  logic [WIDTH-1:0]       res_d;
  logic                   carry_d, ovf_d, illegal_d, zero_d, is_mul;
  logic [2*WIDTH-1:0]     acc_d;

  assign in_ready  = !reset && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign carryout  = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Extra MSB on the sums captures the carry out of the top bit.
  assign add_w   = {1'b0, a} + {1'b0, b};
  assign sub_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add = (a[M] == b[M]) && (add_w[M] != a[M]);
  assign ovf_sub = (a[M] != b[M]) && (sub_w[M] != a[M]);
  assign shamt   = b[SHW-1:0];
  assign a_s     = a;

  // Single-cycle result; MUL only flags is_mul and is finished by the iterator.
  always_comb begin
    res_d     = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    is_mul    = 1'b0;
    case (op)
      4'b0000: begin res_d = add_w[M:0]; carry_d = add_w[WIDTH]; ovf_d = ovf_add; end
      4'b0001: begin res_d = sub_w[M:0]; carry_d = sub_w[WIDTH]; ovf_d = ovf_sub; end
      4'b0010: res_d = a ^ b;
      // Sign of the difference corrected by overflow keeps SLT right at the extremes.
      4'b0011: res_d = {{(WIDTH-1){1'b0}}, sub_w[M] ^ ovf_sub};
      4'b0100: res_d = a & b;
      4'b0101: res_d = ~(a & b);
      4'b0110: res_d = a | b;
      4'b0111: res_d = ~(a | b);
      4'b1000: begin
        if (ENABLE_MUL) is_mul = 1'b1;
        else            illegal_d = 1'b1;
      end
      4'b1001: res_d = a << shamt;
      4'b1010: res_d = a >> shamt;
      4'b1011: res_d = a_s >>> shamt;
      default: illegal_d = 1'b1;
    endcase
    zero_d = (res_d == '0);
  end

  // One partial product per cycle: add the shifted multiplicand when the low multiplier bit is set.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state_q  <= BUSY;
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              cnt_q    <= '0;
            end else begin
              state_q   <= HOLD;
              result_q  <= res_d;
              carry_q   <= carry_d;
              ovf_q     <= ovf_d;
              zero_q    <= zero_d;
              illegal_q <= illegal_d;
            end
          end else if ((state_q == HOLD) && out_ready) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_q   <= HOLD;
            result_q  <= acc_d[M:0];
            carry_q   <= 1'b0;
            ovf_q     <= |acc_d[2*WIDTH-1:WIDTH];
            zero_q    <= (acc_d[M:0] == '0);
            illegal_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        carryout, overflow, zero, illegal;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  alu_pipe #(.WIDTH(32), .ENABLE_MUL(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {32'h0, result}, 64'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        chk("result_flags", {27'h0, result, carryout, overflow, zero, illegal},
            {27'h0, e.res, e.c, e.o, e.z, e.ill});
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o,
                              input logic z, input logic ill);
    exp_t e;
    e.res = r; e.c = c; e.o = o; e.z = z; e.ill = ill;
    return e;
  endfunction

  // Returns just after the accepting edge (inputs then released).
  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input exp_t e);
    bit ok;
    ok = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      chk("accept_timeout", 64'h0, 64'h1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 32'hA5A5_5A5A; b = 32'h5A5A_A5A5; op = 4'b0010;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    int edges;
    int rdy_hi;
    int base;

    // Reset state while reset is asserted, then in_ready once released in IDLE.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_outputs", {59'h0, result == 32'h0, carryout, overflow, zero, illegal},
        {59'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // ADD with latency check: result visible right after the accepting edge.
    send(4'b0000, 32'd1, 32'hFFFF_FFFB, mk(32'hFFFF_FFFC, 0, 0, 0, 0));
    chk("add_latency", 64'(out_valid), 64'h1);
    send(4'b0000, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 0, 1, 0, 0));
    send(4'b0001, 32'd1, 32'hFFFF_FFFB, mk(32'd6, 0, 0, 0, 0));
    send(4'b0001, 32'd5, 32'd5, mk(32'd0, 1, 0, 1, 0));
    send(4'b0011, 32'h8000_0000, 32'd1, mk(32'd1, 0, 0, 0, 0));
    send(4'b0011, 32'd1, 32'hFFFF_FFFB, mk(32'd0, 0, 0, 1, 0));
    send(4'b0100, 32'hFF00_FF00, 32'h0FF0_0FF0, mk(32'h0F00_0F00, 0, 0, 0, 0));
    send(4'b0101, 32'hFF00_FF00, 32'h0FF0_0FF0, mk(32'hF0FF_F0FF, 0, 0, 0, 0));
    send(4'b0110, 32'hFF00_FF00, 32'h0FF0_0FF0, mk(32'hFFF0_FFF0, 0, 0, 0, 0));
    send(4'b1001, 32'd1, 32'd31, mk(32'h8000_0000, 0, 0, 0, 0));
    send(4'b1011, 32'h8000_0000, 32'd4, mk(32'hF800_0000, 0, 0, 0, 0));
    send(4'b1010, 32'h8000_0000, 32'd4, mk(32'h0800_0000, 0, 0, 0, 0));
    send(4'b1001, 32'd1, 32'h21, mk(32'd2, 0, 0, 0, 0));
    send(4'b1101, 32'd7, 32'd9, mk(32'd0, 0, 0, 1, 1));
    drain();

    // MUL under backpressure: count edges to out_valid, in_ready must stay low.
    out_ready = 1'b0;
    send(4'b1000, 32'd7, 32'd6, mk(32'd42, 0, 0, 0, 0));
    edges = 1;
    rdy_hi = 0;
    while (!out_valid && edges < 100) begin
      if (in_ready) rdy_hi++;
      @(posedge clk);
      #1;
      edges++;
    end
    chk("mul_latency_edges", 64'(edges), 64'd33);
    repeat (5) begin
      if (in_ready) rdy_hi++;
      @(posedge clk);
    end
    #1;
    chk("mul_in_ready_low", 64'(rdy_hi), 64'd0);
    chk("mul_hold", {31'h0, out_valid, result}, {31'h0, 1'b1, 32'd42});
    out_ready = 1'b1;
    drain();

    send(4'b1000, 32'h0001_0000, 32'h0001_0000, mk(32'd0, 0, 1, 1, 0));
    drain();

    // Back-to-back: three ops on consecutive edges give consecutive outputs.
    base = pop_cyc.size();
    send(4'b0000, 32'd3, 32'd4, mk(32'd7, 0, 0, 0, 0));
    send(4'b0010, 32'h0000_F0F0, 32'h0000_0FF0, mk(32'h0000_FF00, 0, 0, 0, 0));
    send(4'b0111, 32'd0, 32'd0, mk(32'hFFFF_FFFF, 0, 0, 0, 0));
    drain();
    chk("b2b_count", 64'(pop_cyc.size() - base), 64'd3);
    if (pop_cyc.size() - base == 3) begin
      chk("b2b_gap0", 64'(pop_cyc[base+1] - pop_cyc[base]), 64'd1);
      chk("b2b_gap1", 64'(pop_cyc[base+2] - pop_cyc[base+1]), 64'd1);
    end

    // Reset in the middle of a MUL drops it.
    send(4'b1000, 32'd123, 32'd456, mk(32'd56088, 0, 0, 0, 0));
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midmul_rst_valid", 64'(out_valid), 64'h0);
    chk("midmul_rst_result", {31'h0, zero, result}, {31'h0, 1'b1, 32'h0});
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(4'b0000, 32'd2, 32'd2, mk(32'd4, 0, 0, 0, 0));
    chk("post_rst_latency", 64'(out_valid), 64'h1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
